// File: rtl/mips_hazard_scoreboard_pkg.sv
// Shared types and constants for the MIPS-lite RAW-hazard scoreboard:
// opcodes, the in-flight entry record, forward-select encoding and an IR decoder.
package mips_hazard_scoreboard_pkg;

  localparam int unsigned DEST_W = 5;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned IMM_W  = 16;

  localparam logic [OP_W-1:0] OP_ADD   = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd1;
  localparam logic [OP_W-1:0] OP_AND   = 6'd2;
  localparam logic [OP_W-1:0] OP_OR    = 6'd3;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd4;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd5;
  localparam logic [OP_W-1:0] OP_LOAD  = 6'd6;
  localparam logic [OP_W-1:0] OP_STORE = 6'd7;
  localparam logic [OP_W-1:0] OP_BZ    = 6'd8;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd9;
  localparam logic [OP_W-1:0] OP_JR    = 6'd10;
  localparam logic [OP_W-1:0] OP_HALT  = 6'd11;

  // Forward-select encoding: k selects the value held in stage k-1.
  localparam int unsigned FWD_RF  = 0;
  localparam int unsigned FWD_EX  = 1;
  localparam int unsigned FWD_MEM = 2;

  typedef struct packed {
    logic              valid;
    logic [DEST_W-1:0] dest;
    logic              we;
    logic              is_load;
    logic              is_halt;
  } entry_t;

  typedef struct packed {
    logic [DEST_W-1:0] rs;
    logic [DEST_W-1:0] rt;
    logic [IMM_W-1:0]  imm;
    logic [DEST_W-1:0] dest;
    logic              we;
    logic              is_load;
    logic              is_halt;
    logic              rs_used;
    logic              rt_used;
  } ir_dec_t;

  // IR layout: op[31:26] rs[25:21] rt[20:16] rd[15:11] / imm[15:0].
  function automatic ir_dec_t decode_ir(input logic [31:0] ir);
    ir_dec_t d;
    d         = '0;
    d.rs      = ir[25:21];
    d.rt      = ir[20:16];
    d.imm     = ir[15:0];
    unique case (ir[31:26])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
        d.dest = ir[15:11]; d.we = 1'b1; d.rs_used = 1'b1; d.rt_used = 1'b1;
      end
      OP_ADDI: begin
        d.dest = ir[20:16]; d.we = 1'b1; d.rs_used = 1'b1;
      end
      OP_LOAD: begin
        d.dest = ir[20:16]; d.we = 1'b1; d.is_load = 1'b1; d.rs_used = 1'b1;
      end
      OP_STORE, OP_BEQ: begin
        d.rs_used = 1'b1; d.rt_used = 1'b1;
      end
      OP_BZ, OP_JR: d.rs_used = 1'b1;
      OP_HALT:      d.is_halt = 1'b1;
      default:      d = d;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mips_hazard_scoreboard_match.sv
// Per-source comparator: youngest in-flight stage that writes the given source register.
module mips_hazard_match
  import mips_hazard_scoreboard_pkg::*;
#(
  parameter  int unsigned PIPE_DEPTH = 3,
  parameter  bit          R0_ZERO    = 1'b0,
  localparam int unsigned IDX_W      = $clog2(PIPE_DEPTH)
) (
  input  entry_t [PIPE_DEPTH-1:0] entries_i,
  input  logic   [DEST_W-1:0]     src_i,
  input  logic                    src_used_i,
  output logic                    hit_c_o,
  output logic   [IDX_W-1:0]      stage_c_o,
  output logic                    load_c_o
);

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit_c_o   = 1'b0;
    stage_c_o = '0;
    load_c_o  = 1'b0;
    for (int j = int'(PIPE_DEPTH) - 1; j >= 0; j--) begin
      if (src_used_i && entries_i[j].valid && entries_i[j].we &&
          (entries_i[j].dest == src_i) &&
          !(R0_ZERO && (entries_i[j].dest == '0))) begin
        hit_c_o   = 1'b1;
        stage_c_o = IDX_W'(j);
        load_c_o  = entries_i[j].is_load;
      end
    end
  end

endmodule

// File: rtl/mips_hazard_scoreboard.sv
// RAW-hazard scoreboard for the 5-stage MIPS-lite pipeline: ID stall, bypass
// selects, in-flight destination tracking EX..WB and halt-frozen statistics.
module mips_hazard_scoreboard
  import mips_hazard_scoreboard_pkg::*;
#(
  parameter  int unsigned NUM_REGS   = 32,
  parameter  int unsigned PIPE_DEPTH = 3,
  parameter  bit          FORWARD_EN = 1'b0,
  parameter  bit          R0_ZERO    = 1'b0,
  parameter  int unsigned CNT_W      = 32,
  localparam int unsigned REG_AW     = $clog2(NUM_REGS),
  localparam int unsigned SEL_W      = $clog2(PIPE_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic              id_rs_used,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_dest_we,
  input  logic              id_is_load,
  input  logic              id_is_halt,
  input  logic              id_flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  instr_cnt
);

  localparam int unsigned IDX_W = $clog2(PIPE_DEPTH);
  localparam int unsigned LAST  = PIPE_DEPTH - 1;

  entry_t [PIPE_DEPTH-1:0] ent_q, ent_d;
  logic                    halted_q, halted_d;
  logic [CNT_W-1:0]        cyc_q, cyc_d, stl_q, stl_d, ins_q, ins_d;

  logic             rs_hit, rt_hit, rs_ld, rt_ld;
  logic [IDX_W-1:0] rs_stage, rt_stage;
  logic             gate_c, rs_win, rt_win, rs_ldu, rt_ldu, stall_c, issue_c;
  logic [SEL_W-1:0] rs_sel_c, rt_sel_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  mips_hazard_match #(.PIPE_DEPTH(PIPE_DEPTH), .R0_ZERO(R0_ZERO)) u_match_rs (
    .entries_i (ent_q),
    .src_i     (DEST_W'(id_rs)),
    .src_used_i(id_rs_used),
    .hit_c_o   (rs_hit),
    .stage_c_o (rs_stage),
    .load_c_o  (rs_ld)
  );

  mips_hazard_match #(.PIPE_DEPTH(PIPE_DEPTH), .R0_ZERO(R0_ZERO)) u_match_rt (
    .entries_i (ent_q),
    .src_i     (DEST_W'(id_rt)),
    .src_used_i(id_rt_used),
    .hit_c_o   (rt_hit),
    .stage_c_o (rt_stage),
    .load_c_o  (rt_ld)
  );

  // WB writes in the first half-cycle, so only stages before WB form the hazard window.
  always_comb begin
    gate_c   = id_valid && !id_flush && !halted_q;
    rs_win   = rs_hit && (rs_stage < IDX_W'(LAST));
    rt_win   = rt_hit && (rt_stage < IDX_W'(LAST));
    rs_ldu   = rs_win && (rs_stage == '0) && rs_ld;
    rt_ldu   = rt_win && (rt_stage == '0) && rt_ld;
    stall_c  = 1'b0;
    rs_sel_c = SEL_W'(FWD_RF);
    rt_sel_c = SEL_W'(FWD_RF);
    if (FORWARD_EN) begin
      stall_c = gate_c && (rs_ldu || rt_ldu);
      if (gate_c && rs_win && !rs_ldu) rs_sel_c = SEL_W'(rs_stage) + SEL_W'(FWD_EX);
      if (gate_c && rt_win && !rt_ldu) rt_sel_c = SEL_W'(rt_stage) + SEL_W'(FWD_EX);
    end else begin
      stall_c = gate_c && (rs_win || rt_win);
    end
    issue_c = gate_c && !stall_c;
  end

  always_comb begin
    ent_d    = ent_q;
    halted_d = halted_q;
    cyc_d    = cyc_q;
    stl_d    = stl_q;
    ins_d    = ins_q;
    if (!halted_q) begin
      for (int j = int'(LAST); j > 0; j--) ent_d[j] = ent_q[j-1];
      ent_d[0] = '0;
      if (issue_c) begin
        ent_d[0] = '{valid: 1'b1, dest: DEST_W'(id_dest), we: id_dest_we,
                     is_load: id_is_load, is_halt: id_is_halt};
      end
      halted_d = ent_q[LAST].valid && ent_q[LAST].is_halt;
      cyc_d    = sat_inc(cyc_q, 1'b1);
      stl_d    = sat_inc(stl_q, stall_c);
      ins_d    = sat_inc(ins_q, issue_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q    <= '0;
      halted_q <= 1'b0;
      cyc_q    <= '0;
      stl_q    <= '0;
      ins_q    <= '0;
    end else begin
      ent_q    <= ent_d;
      halted_q <= halted_d;
      cyc_q    <= cyc_d;
      stl_q    <= stl_d;
      ins_q    <= ins_d;
    end
  end

  assign stall      = stall_c;
  assign fwd_rs_sel = rs_sel_c;
  assign fwd_rt_sel = rt_sel_c;
  assign halted     = halted_q;
  assign cycle_cnt  = cyc_q;
  assign stall_cnt  = stl_q;
  assign instr_cnt  = ins_q;

endmodule
